conv_scheduler: RTL
===================

CONV_SCHEDULER -- requirements
Module: conv_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- IMG_W, 28, input image width and height in pixels.
- K, 3, kernel width and height.
- OUT_W, 26, output width and height; fixed at IMG_W-K+1.
REQ-002 The block SHALL have exactly these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on the rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse that begins a frame.
- cfg_bias, in, 8, unsigned bias; sampled on accepted start.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle pulse after the last result write.
- wmem_rd, out, 1, kernel memory read strobe.
- wmem_addr, out, 4, kernel tap address 0..8.
- wmem_rdata, in, 8, kernel data; valid 1 cycle after wmem_rd.
- img_rd, out, 1, image memory read strobe.
- img_addr, out, 10, pixel address 0..783.
- img_rdata, in, 8, pixel data; valid 1 cycle after img_rd.
- pe_valid, out, 1, tap pair valid toward the PE.
- pe_ready, in, 1, PE accepts the tap when high with pe_valid.
- pe_pixel, out, 8, tap pixel.
- pe_weight, out, 8, tap weight.
- pe_first, out, 1, marks tap 0 of a window.
- pe_last, out, 1, marks tap 8 of a window.
- res_valid, in, 1, PE window sum valid; one cycle per window.
- res_data, in, 16, PE unsigned window sum.
- out_we, out, 1, result memory write strobe.
- out_addr, out, 10, result index 0..675.
- out_data, out, 16, biased result.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD_K, RUN, DRAIN and DONE.
REQ-004 State transitions:
- IDLE to LOAD_K on start.
- LOAD_K to RUN after 9 kernel words are captured.
- RUN to DRAIN after the tap with pe_last for window 675 is accepted.
- DRAIN to DONE when result 675 is written.
- DONE to IDLE unconditionally after 1 cycle.
REQ-005 start SHALL be ignored outside IDLE; start and cfg_bias SHALL be sampled only in IDLE.
REQ-006 LOAD_K SHALL:
- issue wmem_rd on 9 consecutive cycles with wmem_addr 0,1,...,8;
- store each returned word in an internal 9-entry weight register file;
- complete in 10 cycles.
REQ-007 Window order SHALL be row-major: r=0..25 outer, c=0..25 inner. Output index SHALL be r*26+c.
REQ-008 Within a window, taps SHALL be issued in order t=ky*3+kx, t=0..8:
- img_addr = (r+ky)*28 + (c+kx);
- pe_weight = weight[t];
- pe_first = (t==0); pe_last = (t==8).
REQ-009 pe_valid/pe_ready handshake:
- A tap transfers only in a cycle where pe_valid and pe_ready are both high.
- While pe_valid is high and pe_ready is low, pe_pixel, pe_weight, pe_first and pe_last SHALL hold stable.
- pe_valid SHALL NOT drop until its tap transfers.
REQ-010 At most one image read SHALL be outstanding. img_rd SHALL be issued only if its data can be held in the pe output register (register empty, or emptying this cycle). No tap SHALL be dropped or duplicated under any pe_ready pattern.
REQ-011 With pe_ready held high, the block SHALL transfer one tap per cycle. The first pe_valid SHALL appear 2 cycles after RUN is entered. One frame SHALL take exactly 6084 tap transfers.
REQ-012 Result path:
- On each res_valid in RUN or DRAIN, the block SHALL register out_we=1, out_data = res_data + {8'b0, bias} (mod 2^16, wraps) and out_addr = result counter, visible the next cycle.
- The result counter SHALL increment 0..675.
- res_valid in IDLE, LOAD_K or DONE SHALL be ignored.
REQ-013 Result ordering:
- Results are written in arrival order; the PE is responsible for returning sums in window order.
- res_valid may coincide with any tap transfer and SHALL NOT stall tap issue.
REQ-014 done SHALL pulse in the DONE state, exactly 1 cycle after out_we for index 675. busy SHALL be low in that same cycle.
REQ-015 All arithmetic SHALL be unsigned.

Reset
REQ-016 While reset_n is low, the block SHALL hold state IDLE and clear all counters. These outputs SHALL be 0: busy, done, wmem_rd, wmem_addr, img_rd, img_addr, pe_valid, pe_pixel, pe_weight, pe_first, pe_last, out_we, out_addr, out_data.
REQ-017 Reset assertion mid-frame SHALL abort the frame immediately, with no further writes. The next start after release SHALL begin a full new frame from kernel load.

Verification
REQ-018 Kernel load: start with wmem returning 1..9 -> wmem_addr 0..8 on consecutive cycles; first pe_weight values are 1,2,...,9 in order.
REQ-019 Addressing: pe_ready=1 -> window 0 img_addr sequence 0,1,2,28,29,30,56,57,58; window 27 (r=1,c=1) begins at addr 29; last tap of frame at addr 783.
REQ-020 Backpressure: pe_ready random at 30% -> exactly 6084 transfers; every tap matches the reference sequence; outputs stable while stalled.
REQ-021 Bias wrap: res_data=16'hFFF0, cfg_bias=8'h20 -> out_data=16'h0010; out_addr sequence 0..675; done pulses once after the index-675 write.
REQ-022 Abort: reset_n low during window 300 -> all outputs 0 within the reset cycle; a new start yields out_addr starting at 0.
REQ-023 Ignored start: start pulsed during RUN -> no restart, total transfer count unchanged.

Source files
------------

// File: rtl/conv_scheduler.sv
// conv_scheduler: walks a KxK kernel over an IMG_W x IMG_W image in row-major
// window order, feeding (pixel, weight) tap pairs to an external PE through a
// valid/ready port, and writes the biased PE window sums to a result memory.
module conv_scheduler #(
  parameter int IMG_W = 28,
  parameter int K     = 3,
  parameter int OUT_W = IMG_W - K + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  cfg_bias,
  output logic        busy,
  output logic        done,
  output logic        wmem_rd,
  output logic [3:0]  wmem_addr,
  input  logic [7:0]  wmem_rdata,
  output logic        img_rd,
  output logic [9:0]  img_addr,
  input  logic [7:0]  img_rdata,
  output logic        pe_valid,
  input  logic        pe_ready,
  output logic [7:0]  pe_pixel,
  output logic [7:0]  pe_weight,
  output logic        pe_first,
  output logic        pe_last,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  output logic        out_we,
  output logic [9:0]  out_addr,
  output logic [15:0] out_data
);

  localparam int NTAP = K * K;
  localparam int NWIN = OUT_W * OUT_W;
  localparam int RCW  = $clog2(OUT_W);
  localparam int KW   = (K > 1) ? $clog2(K) : 1;
  localparam int AW   = 10;

  typedef enum logic [2:0] {IDLE, LOAD_K, RUN, DRAIN, DONE} state_t;

  state_t           r_state, w_state_next;
  logic [3:0]       r_kcnt;
  logic [7:0]       r_w [NTAP];
  logic [7:0]       r_bias;

  // issue-side window/tap position
  logic [RCW-1:0]   r_row, r_col;
  logic [KW-1:0]    r_ky, r_kx;
  logic [3:0]       r_tap;
  logic             r_iss_done;

  // the single read in flight (its data returns this cycle when r_pend is set)
  logic             r_pend;
  logic [3:0]       r_pend_tap;
  logic             r_pend_final;

  // PE output register and the one-entry side buffer behind it
  logic             r_pe_valid, r_pe_first, r_pe_last, r_pe_final;
  logic [7:0]       r_pe_pixel, r_pe_weight;
  logic             r_sk_valid, r_sk_first, r_sk_last, r_sk_final;
  logic [7:0]       r_sk_pixel, r_sk_weight;

  // result path
  logic [9:0]       r_res_cnt;
  logic             r_out_we;
  logic [9:0]       r_out_addr;
  logic [15:0]      r_out_data;

  logic             w_start_acc, w_xfer, w_img_rd, w_is_final, w_res_acc;
  logic [1:0]       w_occ;
  logic [AW-1:0]    w_img_addr;
  logic [7:0]       w_arr_weight;
  logic             w_arr_first, w_arr_last;

  assign w_start_acc  = (r_state == IDLE) && start;
  assign w_xfer       = r_pe_valid && pe_ready;
  // slots that will still be occupied after this cycle; a new read needs one free
  assign w_occ        = {1'b0, r_pe_valid} + {1'b0, r_sk_valid} + {1'b0, r_pend} - {1'b0, w_xfer};
  assign w_img_rd     = (r_state == RUN) && !r_iss_done && (w_occ <= 2'd1);
  assign w_img_addr   = (AW'(r_row) + AW'(r_ky)) * AW'(IMG_W) + AW'(r_col) + AW'(r_kx);
  assign w_is_final   = (r_row == RCW'(OUT_W - 1)) && (r_col == RCW'(OUT_W - 1)) &&
                        (r_ky == KW'(K - 1)) && (r_kx == KW'(K - 1));
  assign w_arr_weight = r_w[r_pend_tap];
  assign w_arr_first  = (r_pend_tap == 4'd0);
  assign w_arr_last   = (r_pend_tap == 4'(NTAP - 1));
  assign w_res_acc    = res_valid && ((r_state == RUN) || (r_state == DRAIN)) &&
                        (r_res_cnt < 10'(NWIN));

  assign img_rd    = w_img_rd;
  assign img_addr  = w_img_rd ? w_img_addr : '0;
  assign pe_valid  = r_pe_valid;
  assign pe_pixel  = r_pe_pixel;
  assign pe_weight = r_pe_weight;
  assign pe_first  = r_pe_first;
  assign pe_last   = r_pe_last;
  assign out_we    = r_out_we;
  assign out_addr  = r_out_addr;
  assign out_data  = r_out_data;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // next-state logic and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    wmem_rd      = 1'b0;
    wmem_addr    = '0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = LOAD_K;
      end
      LOAD_K: begin
        busy = 1'b1;
        if (r_kcnt < 4'(NTAP)) begin
          wmem_rd   = 1'b1;
          wmem_addr = r_kcnt;
        end
        if (r_kcnt == 4'(NTAP)) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_xfer && r_pe_final) w_state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_out_we && (r_out_addr == 10'(NWIN - 1))) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // kernel-load cycle counter and frame bias capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_kcnt <= '0;
      r_bias <= '0;
    end else if (w_start_acc) begin
      r_kcnt <= '0;
      r_bias <= cfg_bias;
    end else if (r_state == LOAD_K) begin
      r_kcnt <= r_kcnt + 4'd1;
    end
  end

  // weight file: word k returns on load cycle k+1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NTAP; i++) r_w[i] <= '0;
    end else if ((r_state == LOAD_K) && (r_kcnt != 4'd0)) begin
      r_w[r_kcnt - 4'd1] <= wmem_rdata;
    end
  end

  // image read position: kx fastest, then ky, then column, then row
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row <= '0; r_col <= '0; r_ky <= '0; r_kx <= '0; r_tap <= '0; r_iss_done <= 1'b0;
    end else if (w_start_acc) begin
      r_row <= '0; r_col <= '0; r_ky <= '0; r_kx <= '0; r_tap <= '0; r_iss_done <= 1'b0;
    end else if (w_img_rd) begin
      if (r_kx == KW'(K - 1)) begin
        r_kx <= '0;
        if (r_ky == KW'(K - 1)) begin
          r_ky  <= '0;
          r_tap <= '0;
          if (r_col == RCW'(OUT_W - 1)) begin
            r_col <= '0;
            if (r_row == RCW'(OUT_W - 1)) r_iss_done <= 1'b1;
            else                          r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end else begin
          r_ky  <= r_ky + 1'b1;
          r_tap <= r_tap + 4'd1;
        end
      end else begin
        r_kx  <= r_kx + 1'b1;
        r_tap <= r_tap + 4'd1;
      end
    end
  end

  // tag of the read in flight so its pixel can be paired with the right weight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend       <= 1'b0;
      r_pend_tap   <= '0;
      r_pend_final <= 1'b0;
    end else begin
      r_pend       <= w_img_rd;
      r_pend_tap   <= r_tap;
      r_pend_final <= w_is_final;
    end
  end

  // returned pixel lands in the PE register, or in the side buffer while it stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pe_valid <= 1'b0; r_pe_pixel <= '0; r_pe_weight <= '0;
      r_pe_first <= 1'b0; r_pe_last  <= 1'b0; r_pe_final <= 1'b0;
      r_sk_valid <= 1'b0; r_sk_pixel <= '0; r_sk_weight <= '0;
      r_sk_first <= 1'b0; r_sk_last  <= 1'b0; r_sk_final <= 1'b0;
    end else if (!r_pe_valid || w_xfer) begin
      if (r_sk_valid) begin
        r_pe_valid  <= 1'b1;        r_pe_pixel <= r_sk_pixel; r_pe_weight <= r_sk_weight;
        r_pe_first  <= r_sk_first;  r_pe_last  <= r_sk_last;  r_pe_final  <= r_sk_final;
        r_sk_valid  <= r_pend;      r_sk_pixel <= img_rdata;  r_sk_weight <= w_arr_weight;
        r_sk_first  <= w_arr_first; r_sk_last  <= w_arr_last; r_sk_final  <= r_pend_final;
      end else if (r_pend) begin
        r_pe_valid  <= 1'b1;        r_pe_pixel <= img_rdata;  r_pe_weight <= w_arr_weight;
        r_pe_first  <= w_arr_first; r_pe_last  <= w_arr_last; r_pe_final  <= r_pend_final;
      end else begin
        r_pe_valid  <= 1'b0;
      end
    end else if (r_pend) begin
      r_sk_valid  <= 1'b1;        r_sk_pixel <= img_rdata;  r_sk_weight <= w_arr_weight;
      r_sk_first  <= w_arr_first; r_sk_last  <= w_arr_last; r_sk_final  <= r_pend_final;
    end
  end

  // biased result write, addressed by arrival order
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_res_cnt  <= '0;
      r_out_we   <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_out_we <= 1'b0;
      if (w_start_acc) begin
        r_res_cnt <= '0;
      end else if (w_res_acc) begin
        r_out_we   <= 1'b1;
        r_out_addr <= r_res_cnt;
        r_out_data <= res_data + {8'b0, r_bias};
        r_res_cnt  <= r_res_cnt + 10'd1;
      end
    end
  end

endmodule
